div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider; the responder side of the EX-stage divide handshake (start_i/ready_o/annul_i).
- EX holds start_i with operands while stalling the pipeline; the block iterates and returns {remainder, quotient}.
- Serves DIV (signed) and DIVU (unsigned); EX writes the result to HI/LO.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- signed_div_i  input  1  1 = signed divide, 0 = unsigned
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  request; held high by EX until ready_o is seen
- annul_i  input  1  abort the in-flight operation (pipeline flush)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}, registered
- ready_o  output  1  result valid (`DivResultReady`), registered

Behaviour:
- Reset (async): state = FREE, cnt = 0, ready_o = 0, result_o = 0, internal dividend/divisor registers = 0.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON. Latch abs(op1), abs(op2) when signed_div_i=1 (raw values when 0), signed_div_i, op1[31], op2[31]. Clear the 65-bit partial-remainder/quotient shift register; cnt = 0.
  - Otherwise stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: next state END; the result register is set to 64'b0.
- ON, one quotient bit per cycle:
  - Shift {rem, quo} left 1.
  - trial = rem[32:0] - {1'b0, divisor}.
  - trial[32]==0: rem = trial and the new quo bit = 1. Otherwise keep rem and the new quo bit = 0.
  - cnt++.
  - annul_i=1 -> FREE immediately; result is discarded and ready_o stays 0.
  - When cnt reaches DATA_W-1, this is the last step. Next state END, with sign correction applied to the result:
    - quotient negated if the signed flag and op1 sign differ from the op2 sign.
    - remainder negated if the signed flag and the op1 sign are set.
- END:
  - ready_o = 1 and result_o is valid.
  - start_i=0 -> FREE on the next edge: ready_o = 0, result_o = 0.
  - start_i=1 -> hold END, with ready_o and result_o stable.
- Latency, with edge E = start sampled in FREE:
  - Nonzero divisor: ON occupies cycles E+1..E+32; ready_o is high after edge E+33.
  - Zero divisor: ready_o is high after edge E+2.
- Operand changes while in ON/END are ignored; operands are latched only at E.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000 (wrap), remainder 0. No trap.
- annul_i in FREE or END: no effect beyond the start_i rule.
- rst asserted mid-operation: immediate return to the reset state; no partial result is ever visible.
- All arithmetic is modulo 2^DATA_W.
- abs() of 0x80000000 is treated as an unsigned 0x80000000 magnitude.

Decomposition:
- Shared package, defines.vh:
  - State codes `DivFree` / `DivByZero` / `DivOn` / `DivEnd`.
  - `DivStart` / `DivStop`, `DivResultReady` / `DivResultNotReady`, `ZeroWord`.
  - `DivCntW` = 6.
- No sub-module. The state machine plus one subtract/shift datapath fits in a single module of roughly 150-200 lines.

Test Plan:
- Unsigned: op1=100, op2=7, signed=0, start held.
  -> ready_o rises 33 edges after start; result_o = {32'd2, 32'd14}. Drop start -> ready_o=0 and result_o=0 next cycle.
- Signed: op1=-7 (0xFFFFFFF9), op2=2, signed=1.
  -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Divide by zero: op1=5, op2=0.
  -> ready_o high 2 edges after start; result_o=0.
- Overflow: op1=0x80000000, op2=0xFFFFFFFF, signed=1.
  -> quotient 0x80000000, remainder 0.
- Annul and reset:
  - annul_i pulse at ON cycle 10 -> FREE next edge, ready_o never asserts.
  - A fresh start 1 cycle later completes normally: op1=9, op2=3 -> {0, 3}.
  - rst asserted at ON cycle 20 -> outputs zero asynchronously.
- Hold: start_i kept high 5 cycles after ready_o.
  -> ready_o and result_o stable throughout; opdata changes during ON have no effect.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state codes,
// handshake level names and the iteration counter width.
// Ports: none (package).
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  // Levels of the EX-side request and of the result-ready flag.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Wide enough to count DATA_W = 32 iterations.
  localparam int DivCntW = 6;

endpackage : div_iter_pkg

// File: rtl/div_iter.sv
// Radix-2 restoring divider (DIV/DIVU) answering the EX-stage divide handshake.
// Latency: ready_o rises DATA_W+1 edges after start is sampled (2 edges for a zero divisor).
// Backpressure: EX holds start_i; the result is held until start_i drops, annul_i aborts.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   signed_div_i             1 = signed divide, 0 = unsigned
//   opdata1_i / opdata2_i    dividend / divisor, sampled only when the operation starts
//   start_i / annul_i        request (held until ready_o) / flush of the in-flight divide
//   result_o                 {remainder, quotient}, registered, zero unless ready_o
//   ready_o                  registered result-valid flag
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [DivCntW-1:0] LastCnt = DivCntW'(DATA_W - 1);

  div_state_e                state_q, state_d;
  logic [DivCntW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]         dividend_q, dividend_d;  // magnitude, consumed MSB-first
  logic [DATA_W-1:0]         divisor_q, divisor_d;    // magnitude
  logic                      signed_q, signed_d;
  logic                      op1_neg_q, op1_neg_d;
  logic                      op2_neg_q, op2_neg_d;
  logic [DATA_W-1:0]         rem_q, rem_d;            // partial remainder
  logic [DATA_W-1:0]         quo_q, quo_d;            // quotient bits so far
  logic [2*DATA_W-1:0]       res_q, res_d;            // sign-corrected final result
  logic [2*DATA_W-1:0]       result_q, result_d;
  logic                      ready_q, ready_d;

  // One restoring step: bring the next dividend bit into the remainder,
  // try subtracting the divisor and keep the difference if it did not go negative.
  logic [DATA_W:0]           rem_sh;
  logic [DATA_W:0]           trial;
  logic [DATA_W-1:0]         rem_new;
  logic [DATA_W-1:0]         quo_new;
  logic                      q_bit;
  logic [DATA_W-1:0]         rem_fix;
  logic [DATA_W-1:0]         quo_fix;

  always_comb begin
    rem_sh  = {rem_q, dividend_q[DATA_W-1]};
    trial   = rem_sh - {1'b0, divisor_q};
    q_bit   = ~trial[DATA_W];
    rem_new = q_bit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_new = {quo_q[DATA_W-2:0], q_bit};
    // Quotient takes the XOR of the operand signs, remainder follows the dividend.
    quo_fix = (signed_q && (op1_neg_q ^ op2_neg_q)) ? (DATA_W'(0) - quo_new) : quo_new;
    rem_fix = (signed_q && op1_neg_q) ? (DATA_W'(0) - rem_new) : rem_new;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    op1_neg_d  = op1_neg_q;
    op2_neg_d  = op2_neg_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    res_d      = res_q;
    result_d   = '0;
    ready_d    = DivResultNotReady;

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            rem_d      = '0;
            quo_d      = '0;
            signed_d   = signed_div_i;
            op1_neg_d  = opdata1_i[DATA_W-1];
            op2_neg_d  = opdata2_i[DATA_W-1];
            // 0x80000000 negates to itself, which is the correct unsigned magnitude.
            dividend_d = (signed_div_i && opdata1_i[DATA_W-1]) ? (DATA_W'(0) - opdata1_i)
                                                               : opdata1_i;
            divisor_d  = (signed_div_i && opdata2_i[DATA_W-1]) ? (DATA_W'(0) - opdata2_i)
                                                               : opdata2_i;
          end
        end
      end

      DivByZero: begin
        res_d   = '0;
        state_d = DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d      = rem_new;
          quo_d      = quo_new;
          dividend_d = {dividend_q[DATA_W-2:0], 1'b0};
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            res_d   = {rem_fix, quo_fix};
            state_d = DivEnd;
          end
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d = DivFree;
        end else begin
          ready_d  = DivResultReady;
          result_d = res_q;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      op1_neg_q  <= 1'b0;
      op2_neg_q  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      res_q      <= '0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      op1_neg_q  <= op1_neg_d;
      op2_neg_q  <= op2_neg_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      res_q      <= res_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, hand sequences for
// annul/reset/hold, and randomized operations against an arithmetic model.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation for signed, 0 for /0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'h0) return 64'h0;
    if (!s) return {a % b, a / b};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Full handshake: raise start, wait (bounded) for ready, hold, drop start.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input int exp_lat, input int hold,
                       input bit scramble, input string tag);
    int          lat;
    logic [63:0] got;
    lat = -1;
    got = '0;
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = n;
        got = result_o;
        break;
      end
      if (scramble && n == 5) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end
    check64({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check64({tag, " result"}, got, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check64({tag, " hold ready"}, 64'(ready_o), 64'd1);
      check64({tag, " hold result"}, result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check64({tag, " drop ready"}, 64'(ready_o), 64'd0);
    check64({tag, " drop result"}, result_o, 64'h0);
  endtask

  initial begin
    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2,         32'd14},        33};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF,  32'hFFFFFFFD},  33};
    vecs[2]  = '{32'd5,         32'd0,         1'b0, 64'h0,                          2};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h0,         32'h80000000},  33};
    vecs[4]  = '{32'd9,         32'd3,         1'b0, {32'd0,         32'd3},         33};
    vecs[5]  = '{32'hFFFFFFFF,  32'd1,         1'b0, {32'd0,         32'hFFFFFFFF},  33};
    vecs[6]  = '{32'd7,         32'hFFFFFFFE,  1'b1, {32'd1,         32'hFFFFFFFD},  33};
    vecs[7]  = '{32'hFFFFFFF8,  32'hFFFFFFFD,  1'b1, {32'hFFFFFFFE,  32'd2},         33};
    vecs[8]  = '{32'd3,         32'd10,        1'b0, {32'd3,         32'd0},         33};
    vecs[9]  = '{32'hFFFFFFF9,  32'd2,         1'b0, {32'd1,         32'h7FFFFFFC},  33};
    vecs[10] = '{32'h80000000,  32'd0,         1'b1, 64'h0,                          2};
    vecs[11] = '{32'h80000000,  32'd2,         1'b1, {32'd0,         32'hC0000000},  33};

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    check64("reset ready", 64'(ready_o), 64'd0);
    check64("reset result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].lat, 1, 1'b0,
            $sformatf("vec%0d", i));
    end

    // Hold for 5 cycles with operands scrambled mid-iteration.
    do_op(32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 33, 5, 1'b1, "hold");

    // Annul at ON cycle 10, then a fresh start must complete normally.
    begin
      int hits;
      hits = 0;
      @(negedge clk);
      opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (ready_o) hits++;
      end
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (ready_o || result_o != 64'h0) hits++;
      end
      check64("annul no ready", 64'(hits), 64'd0);
    end
    do_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0, 1'b0, "after annul");

    // Async reset at ON cycle 20.
    begin
      int hits;
      hits = 0;
      @(negedge clk);
      opdata1_i = 32'd12345; opdata2_i = 32'd11; signed_div_i = 1'b0; start_i = 1'b1;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check64("rst on ready", 64'(ready_o), 64'd0);
      check64("rst on result", result_o, 64'h0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (ready_o) hits++;
      end
      check64("rst on no ready", 64'(hits), 64'd0);
    end

    // Async reset while the result is being held in END.
    begin
      int          lat;
      logic [63:0] got;
      lat = -1;
      got = '0;
      @(negedge clk);
      opdata1_i = 32'd12; opdata2_i = 32'd5; signed_div_i = 1'b0; start_i = 1'b1;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        if (ready_o) begin
          lat = n;
          got = result_o;
          break;
        end
      end
      check64("end rst latency", 64'(lat), 64'd33);
      check64("end rst result", got, {32'd2, 32'd2});
      #2;
      rst = 1'b1;
      #1;
      check64("rst end ready", 64'(ready_o), 64'd0);
      check64("rst end result", result_o, 64'h0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b0;
    end
    do_op(32'd50, 32'd6, 1'b0, {32'd2, 32'd8}, 33, 0, 1'b0, "after rst");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      logic        s;
      int          mode;
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 32'h0;
      else if (mode == 1) b = $urandom_range(1, 15);
      else if (mode == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 3) a = $urandom_range(0, 100);
      do_op(a, b, s, ref_div(a, b, s), (b == 32'h0) ? 2 : 33, $urandom_range(0, 2), 1'b0,
            $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_iter
